// File: rtl/thunderbolt_time_latch_ctrl.sv
// ---------------------------------------------------------------------------
// thunderbolt_time_latch_ctrl
//
// Purpose:
//   This is the read-coherency controller for the Thunderbolt GPS time fields.
//   It sits between the TSIP decoder and the host register bus. Three banks of
//   time bytes are kept:
//     A - the active, committed time.
//     S - the snapshot that the host reads while locked.
//     P - a pending decoder update that arrived while locked.
//   A read of YEAR_H freezes A into S. The block then holds S until the host
//   reads SECONDS or stops reading for LOCK_TIMEOUT cycles. Because of this, a
//   multi-byte time read never tears across a decoder update.
//
// Optional feature (macro THUNDER_STALE_EN):
//   A 3-bit PPS counter drives o_stale and STATUS bit 3. When the macro is not
//   defined, i_pps is ignored and o_stale is tied low.
//
// Ports:
//   i_clk, i_rst          clock and synchronous active-high reset
//   i_upd_valid           decoder strobe; all i_t_* bytes are coherent this cycle
//   i_t_year_h .. i_t_seconds   live time bytes from the decoder
//   i_pps                 1-cycle PPS pulse, already synchronised
//   i_rd, i_addr          host read strobe and address
//   o_data, o_rd_valid    registered read data, valid 1 cycle after i_rd
//   o_locked              snapshot held
//   o_time_valid          at least one commit to A since reset
//   o_lock_timeout        1-cycle pulse when the lock is released by timeout
//   o_stale               time not refreshed for STALE_LIMIT PPS pulses
//
// Register map (byte addresses):
//   0x00 YEAR_H  0x01 YEAR_L  0x02 MONTH  0x03 DAY  0x04 HOUR
//   0x05 MINUTES 0x06 SECONDS 0x07 STATUS
//   STATUS = {time_valid, locked, pend, overrun, stale, 3'b000}
// ---------------------------------------------------------------------------
module thunderbolt_time_latch_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int LOCK_TIMEOUT = 1000,
  parameter int TO_WIDTH     = 16,
  parameter int STALE_LIMIT  = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_upd_valid,
  input  logic [DATA_WIDTH-1:0] i_t_year_h,
  input  logic [DATA_WIDTH-1:0] i_t_year_l,
  input  logic [DATA_WIDTH-1:0] i_t_month,
  input  logic [DATA_WIDTH-1:0] i_t_day,
  input  logic [DATA_WIDTH-1:0] i_t_hour,
  input  logic [DATA_WIDTH-1:0] i_t_minutes,
  input  logic [DATA_WIDTH-1:0] i_t_seconds,
  input  logic                  i_pps,
  input  logic                  i_rd,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_rd_valid,
  output logic                  o_locked,
  output logic                  o_time_valid,
  output logic                  o_lock_timeout,
  output logic                  o_stale
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_YEAR_H  = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_SECONDS = ADDR_WIDTH'(6);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS  = ADDR_WIDTH'(7);
  localparam logic [TO_WIDTH-1:0]   TIMER_LAST   = TO_WIDTH'(LOCK_TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] a_bank [7];
  logic [DATA_WIDTH-1:0] s_bank [7];
  logic [DATA_WIDTH-1:0] p_bank [7];
  logic [DATA_WIDTH-1:0] in_bank [7];
  logic                  pend;
  logic                  overrun;
  logic                  time_valid;
  logic [TO_WIDTH-1:0]   timer;
  logic                  stale;

  logic [DATA_WIDTH-1:0] data_p1;
  logic                  vld_p1;
  logic                  lock_to_p1;

  logic                  lock_rd;
  logic                  unlock_rd;
  logic                  status_rd;
  logic                  timeout_hit;
  logic                  release_now;
  logic                  commit;
  logic [DATA_WIDTH-1:0] rd_data;

  // Returns the STATUS byte, zero-extended to the bus width.
  function automatic logic [DATA_WIDTH-1:0] status_byte(
    input logic tv, input logic lk, input logic pd, input logic ov, input logic st);
    status_byte = DATA_WIDTH'({tv, lk, pd, ov, st, 3'b000});
  endfunction

  always_comb begin
    in_bank[0] = i_t_year_h;
    in_bank[1] = i_t_year_l;
    in_bank[2] = i_t_month;
    in_bank[3] = i_t_day;
    in_bank[4] = i_t_hour;
    in_bank[5] = i_t_minutes;
    in_bank[6] = i_t_seconds;
  end

  always_comb begin
    lock_rd     = i_rd && (i_addr == ADDR_YEAR_H);
    unlock_rd   = i_rd && (i_addr == ADDR_SECONDS);
    status_rd   = i_rd && (i_addr == ADDR_STATUS);
    timeout_hit = (state == LOCKED) && !i_rd && (timer == TIMER_LAST);
    release_now = (state == LOCKED) && (unlock_rd || timeout_hit);
    // A commit happens on a plain IDLE update (one with no lock in the same
    // cycle), or on release when either live inputs or a pending update exist.
    commit      = ((state == IDLE) && i_upd_valid && !lock_rd) ||
                  (release_now && (i_upd_valid || pend));
  end

  // YEAR_H always returns A. In IDLE, A is what gets frozen. In LOCKED, a
  // YEAR_H read re-snapshots A. Other time fields return S while locked.
  always_comb begin
    rd_data = '0;
    if (i_rd) begin
      if (i_addr == ADDR_YEAR_H)
        rd_data = a_bank[0];
      else if (i_addr < ADDR_STATUS)
        rd_data = (state == LOCKED) ? s_bank[i_addr[2:0]] : a_bank[i_addr[2:0]];
      else if (i_addr == ADDR_STATUS)
        rd_data = status_byte(time_valid, (state == LOCKED), pend, overrun, stale);
    end
  end

  // ---- stage p1: controller state, banks and registered read port ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      pend       <= 1'b0;
      overrun    <= 1'b0;
      time_valid <= 1'b0;
      timer      <= '0;
      data_p1    <= '0;
      vld_p1     <= 1'b0;
      lock_to_p1 <= 1'b0;
      for (int i = 0; i < 7; i++) begin
        a_bank[i] <= '0;
        s_bank[i] <= '0;
        p_bank[i] <= '0;
      end
    end else begin
      data_p1    <= rd_data;
      vld_p1     <= i_rd;
      lock_to_p1 <= 1'b0;
      // The clear happens first so that an overrun raised in the same cycle wins.
      if (status_rd)
        overrun <= 1'b0;
      if (commit)
        time_valid <= 1'b1;

      case (state)
        IDLE: begin
          if (lock_rd) begin
            state <= LOCKED;
            timer <= '0;
            for (int i = 0; i < 7; i++) s_bank[i] <= a_bank[i];
            if (i_upd_valid) begin
              for (int i = 0; i < 7; i++) p_bank[i] <= in_bank[i];
              pend <= 1'b1;
            end
          end else if (i_upd_valid) begin
            for (int i = 0; i < 7; i++) a_bank[i] <= in_bank[i];
          end
        end

        LOCKED: begin
          if (release_now) begin
            state      <= IDLE;
            timer      <= '0;
            pend       <= 1'b0;
            lock_to_p1 <= timeout_hit;
            if (i_upd_valid) begin
              for (int i = 0; i < 7; i++) a_bank[i] <= in_bank[i];
            end else if (pend) begin
              for (int i = 0; i < 7; i++) a_bank[i] <= p_bank[i];
            end
          end else begin
            timer <= i_rd ? '0 : timer + 1'b1;
            if (lock_rd) begin
              for (int i = 0; i < 7; i++) s_bank[i] <= a_bank[i];
            end
            if (i_upd_valid) begin
              for (int i = 0; i < 7; i++) p_bank[i] <= in_bank[i];
              pend <= 1'b1;
              if (pend)
                overrun <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef THUNDER_STALE_EN
  logic [2:0] stale_cnt;

  // A commit clears the counter. The clear beats a PPS pulse in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      stale_cnt <= 3'd0;
    else if (commit)
      stale_cnt <= 3'd0;
    else if (i_pps && (stale_cnt != 3'd7))
      stale_cnt <= stale_cnt + 3'd1;
  end

  assign stale = (32'(stale_cnt) >= STALE_LIMIT);
`else
  logic unused_pps;
  assign unused_pps = i_pps ^ (STALE_LIMIT != 0);
  assign stale      = 1'b0;
`endif

  assign o_data         = data_p1;
  assign o_rd_valid     = vld_p1;
  assign o_locked       = (state == LOCKED);
  assign o_time_valid   = time_valid;
  assign o_lock_timeout = lock_to_p1;
  assign o_stale        = stale;

endmodule
